mine_field_dp: RTL and testbench
================================

// Module: mine_field_dp
// PURPOSE
//  Parametrised successor of the 5x5 Minesweeper datapath: ROWS x COLS field, LFSR mine placement of
//  NUM_MINES mines, true 8-neighbour mine count, and a valid/ready pick handshake in place of
//  load/decode/alu strobes. Sits between the game controller (start/pick) and display/score logic.
// PARAMETERS
//  ROWS       5   field rows, 2..16
//  COLS       5   field columns, 2..16; N = ROWS*COLS cells, cell index = row*COLS+col
//  NUM_MINES  3   mines per game, 1..N-2 (elaboration error otherwise)
//  SCORE_W    32  width of global_score
// PORTS
//  clka          in   1        clock; all state changes on rising edge
//  restart_n     in   1        asynchronous, active-low reset
//  start         in   1        begin new game (one-cycle pulse)
//  seed          in   16       LFSR seed sampled when start is accepted; 0 is replaced by 16'hACE1
//  pick_valid    in   1        pick request
//  pick_ready    out  1        high only in READY
//  pick_row      in   clog2(ROWS)  row of pick
//  pick_col      in   clog2(COLS)  column of pick
//  place_done    out  1        one-cycle pulse when placement completes
//  mines         out  N        mine map, bit i = cell i
//  cleared       out  N        cleared-cell map
//  n_nearby      out  4        mines among the 8 neighbours of last valid pick (0..8)
//  result_valid  out  1        one-cycle pulse: pick evaluated
//  pick_err      out  1        last pick was out of range (row>=ROWS or col>=COLS)
//  gameover      out  1        mine hit or win; held until next start
//  win           out  1        all non-mine cells cleared; held until next start
//  global_score  out  SCORE_W  games won since reset; saturates at all-ones
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, LFSR = 16'hACE1. Reset mid-game/mid-placement aborts immediately.
//  FSM: IDLE -start-> PLACE -NUM_MINES placed-> READY -pick accepted-> EVAL -> READY | OVER;
//   OVER -start-> PLACE. start in IDLE/READY/OVER: clear mines, cleared, n_nearby, gameover, win,
//   pick_err; load LFSR. start during PLACE or EVAL ignored. global_score cleared only by reset.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11, one step per PLACE cycle. Candidate = lfsr % N;
//   set bit if not already a mine (and not excluded cell, see CONFIGURATION), else retry next cycle.
//   Placement latency is data-dependent, >= NUM_MINES cycles. place_done pulses on PLACE->READY edge.
//  Handshake: pick accepted on rising edge with pick_valid && pick_ready; coordinates latched.
//   Next edge (EVAL) updates outputs; result_valid high exactly one cycle after that edge.
//   pick_valid outside READY is ignored and not queued.
//  EVAL: out-of-range -> pick_err=1, no other state change, back to READY.
//   In range: pick_err=0; n_nearby = popcount of mine neighbours, edge/corner cells count only
//   existing neighbours (no wrap across rows/columns); cleared |= cell bit.
//   Cell is mine -> gameover=1, win=0, -> OVER.
//   Else if (cleared|cell) == ~mines -> win=1, gameover=1, score+1 (saturating), -> OVER.
//   Re-picking an already cleared cell: result_valid, n_nearby recomputed, no other change.
// CONFIGURATION
//  FIRST_PICK_SAFE_EN defined: start goes PLACE only after first pick; state ARMED (pick_ready=1)
//   accepts the first pick, placement excludes that cell and its neighbours are still eligible,
//   then the pick is evaluated as EVAL without a further handshake; place_done pulses before
//   result_valid. Requires NUM_MINES <= N-1. Out-of-range first pick: pick_err, stay ARMED.
//  Not defined: placement runs immediately on start; first pick may hit a mine.
// TESTING
//  Reset mid-PLACE with restart_n low 1 ns off-edge -> all outputs 0 asynchronously, IDLE.
//  5x5, NUM_MINES=3, seed=16'h1234 -> place_done once, popcount(mines)=3, match reference LFSR model.
//  Pick (0,0) with mines at 1,5,6 -> n_nearby=3; pick (4,4) with no neighbours -> n_nearby=0.
//  Pick row=5 on 5x5 -> result_valid, pick_err=1, cleared unchanged, pick_ready back high.
//  Clear all 22 safe cells -> final result_valid with win=1, gameover=1, score 0->1; start keeps 1.
//  Pick mine cell -> gameover=1, win=0, pick_ready=0; pick_valid held high -> ignored until start.

Source files
------------

// File: rtl/mine_field_if.sv
// Signal bundle between the game controller (master) and the minefield datapath (slave).
interface mine_field_if #(
  parameter int unsigned ROWS    = 5,
  parameter int unsigned COLS    = 5,
  parameter int unsigned SCORE_W = 32
);
  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);

  logic               start;
  logic [15:0]        seed;
  logic               pick_valid;
  logic               pick_ready;
  logic [RW-1:0]      pick_row;
  logic [CW-1:0]      pick_col;
  logic               place_done;
  logic [N-1:0]       mines;
  logic [N-1:0]       cleared;
  logic [3:0]         n_nearby;
  logic               result_valid;
  logic               pick_err;
  logic               gameover;
  logic               win;
  logic [SCORE_W-1:0] global_score;

  modport master (
    output start, seed, pick_valid, pick_row, pick_col,
    input  pick_ready, place_done, mines, cleared, n_nearby, result_valid,
           pick_err, gameover, win, global_score
  );

  modport slave (
    input  start, seed, pick_valid, pick_row, pick_col,
    output pick_ready, place_done, mines, cleared, n_nearby, result_valid,
           pick_err, gameover, win, global_score
  );
endinterface

// File: rtl/mine_field_dp.sv
// ROWS x COLS minesweeper datapath: LFSR mine placement, 8-neighbour count, pick handshake, score.
// Optional FIRST_PICK_SAFE_EN: placement deferred until the first pick, which is never a mine.
module mine_field_dp #(
  parameter int unsigned ROWS      = 5,
  parameter int unsigned COLS      = 5,
  parameter int unsigned NUM_MINES = 3,
  parameter int unsigned SCORE_W   = 32
) (
  input  logic        clka,
  input  logic        restart_n,
  mine_field_if.slave bus
);
  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned PW = $clog2(NUM_MINES + 1);
  localparam logic [15:0] LFSR_INIT = 16'hACE1;

  if (ROWS < 2 || ROWS > 16 || COLS < 2 || COLS > 16) begin : g_bad_dims
    $error("mine_field_dp: ROWS and COLS must be within 2..16");
  end
  if (NUM_MINES < 1 || NUM_MINES > N - 2) begin : g_bad_mines
    $error("mine_field_dp: NUM_MINES must be within 1..N-2");
  end

  typedef enum logic [2:0] {S_IDLE, S_PLACE, S_READY, S_EVAL, S_OVER, S_ARMED} state_e;

  state_e             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [N-1:0]       mines_q, mines_d, cleared_q, cleared_d;
  logic [3:0]         nearby_q, nearby_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [RW-1:0]      row_q, row_d;
  logic [CW-1:0]      col_q, col_d;
  logic [PW-1:0]      placed_q, placed_d;
  logic               rv_q, rv_d, err_q, err_d, go_q, go_d, win_q, win_d;
  logic               pd_q, pd_d, ready_q, ready_d;

  logic [IW-1:0]      pick_idx_c, cand_idx_c;
  logic [N-1:0]       cell_c;
  logic [15:0]        lfsr_nx_c;
  logic               excl_hit_c;

  function automatic logic in_range(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return (int'(r) < int'(ROWS)) && (int'(c) < int'(COLS));
  endfunction

  // Only neighbours inside the field count; no wrap across row or column edges.
  function automatic logic [3:0] count_nearby(input logic [N-1:0] m, input int r, input int c);
    int cnt;
    cnt = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if ((dr != 0 || dc != 0) && (r + dr >= 0) && (r + dr < int'(ROWS)) &&
            (c + dc >= 0) && (c + dc < int'(COLS))) begin
          if (m[IW'((r + dr) * int'(COLS) + c + dc)]) cnt++;
        end
      end
    end
    return 4'(cnt);
  endfunction

  assign pick_idx_c = IW'(int'(row_q) * int'(COLS) + int'(col_q));
  assign cell_c     = N'(1) << pick_idx_c;
  assign lfsr_nx_c  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign cand_idx_c = IW'(lfsr_q % 16'(N));

`ifdef FIRST_PICK_SAFE_EN
  localparam state_e START_TO = S_ARMED;
  localparam state_e PLACE_TO = S_EVAL;
  // The latched first pick stays in row_q/col_q throughout placement.
  assign excl_hit_c = (cand_idx_c == pick_idx_c);
`else
  localparam state_e START_TO = S_PLACE;
  localparam state_e PLACE_TO = S_READY;
  assign excl_hit_c = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    mines_d   = mines_q;
    cleared_d = cleared_q;
    nearby_d  = nearby_q;
    score_d   = score_q;
    row_d     = row_q;
    col_d     = col_q;
    placed_d  = placed_q;
    err_d     = err_q;
    go_d      = go_q;
    win_d     = win_q;
    rv_d      = 1'b0;
    pd_d      = 1'b0;

    unique case (state_q)
      S_PLACE: begin
        lfsr_d = lfsr_nx_c;
        if (!mines_q[cand_idx_c] && !excl_hit_c) begin
          mines_d[cand_idx_c] = 1'b1;
          placed_d            = placed_q + PW'(1);
          if (placed_q == PW'(NUM_MINES - 1)) begin
            pd_d    = 1'b1;
            state_d = PLACE_TO;
          end
        end
      end
      S_READY: begin
        if (bus.pick_valid && ready_q) begin
          row_d   = bus.pick_row;
          col_d   = bus.pick_col;
          state_d = S_EVAL;
        end
      end
`ifdef FIRST_PICK_SAFE_EN
      S_ARMED: begin
        if (bus.pick_valid && ready_q) begin
          row_d = bus.pick_row;
          col_d = bus.pick_col;
          if (in_range(bus.pick_row, bus.pick_col)) begin
            state_d = S_PLACE;
          end else begin
            err_d = 1'b1;
            rv_d  = 1'b1;
          end
        end
      end
`endif
      S_EVAL: begin
        rv_d = 1'b1;
        if (!in_range(row_q, col_q)) begin
          err_d   = 1'b1;
          state_d = S_READY;
        end else begin
          err_d     = 1'b0;
          nearby_d  = count_nearby(mines_q, int'(row_q), int'(col_q));
          cleared_d = cleared_q | cell_c;
          if (mines_q[pick_idx_c]) begin
            go_d    = 1'b1;
            win_d   = 1'b0;
            state_d = S_OVER;
          end else if ((cleared_q | cell_c) == ~mines_q) begin
            go_d    = 1'b1;
            win_d   = 1'b1;
            state_d = S_OVER;
            if (score_q != {SCORE_W{1'b1}}) score_d = score_q + SCORE_W'(1);
          end else begin
            state_d = S_READY;
          end
        end
      end
      default: ;
    endcase

    // A new game may begin from any resting state; placement and evaluation are never interrupted.
    if (bus.start && (state_q == S_IDLE || state_q == S_READY ||
                      state_q == S_OVER || state_q == S_ARMED)) begin
      mines_d   = '0;
      cleared_d = '0;
      nearby_d  = '0;
      err_d     = 1'b0;
      go_d      = 1'b0;
      win_d     = 1'b0;
      placed_d  = '0;
      lfsr_d    = (bus.seed == 16'h0000) ? LFSR_INIT : bus.seed;
      state_d   = START_TO;
    end

    ready_d = (state_d == S_READY) || (state_d == S_ARMED);
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q   <= S_IDLE;
      lfsr_q    <= LFSR_INIT;
      mines_q   <= '0;
      cleared_q <= '0;
      nearby_q  <= '0;
      score_q   <= '0;
      row_q     <= '0;
      col_q     <= '0;
      placed_q  <= '0;
      rv_q      <= 1'b0;
      err_q     <= 1'b0;
      go_q      <= 1'b0;
      win_q     <= 1'b0;
      pd_q      <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      mines_q   <= mines_d;
      cleared_q <= cleared_d;
      nearby_q  <= nearby_d;
      score_q   <= score_d;
      row_q     <= row_d;
      col_q     <= col_d;
      placed_q  <= placed_d;
      rv_q      <= rv_d;
      err_q     <= err_d;
      go_q      <= go_d;
      win_q     <= win_d;
      pd_q      <= pd_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.pick_ready   = ready_q;
  assign bus.place_done   = pd_q;
  assign bus.mines        = mines_q;
  assign bus.cleared      = cleared_q;
  assign bus.n_nearby     = nearby_q;
  assign bus.result_valid = rv_q;
  assign bus.pick_err     = err_q;
  assign bus.gameover     = go_q;
  assign bus.win          = win_q;
  assign bus.global_score = score_q;
endmodule

// File: tb/tb_mine_field_dp.sv
// Randomised game bench for mine_field_dp (5x5, 3 mines) against a cell-level game model.
module tb_mine_field_dp;
  localparam int unsigned ROWS = 5;
  localparam int unsigned COLS = 5;
  localparam int unsigned NM   = 3;
  localparam int unsigned SW   = 32;
  localparam int unsigned N    = ROWS * COLS;

  logic clka      = 1'b0;
  logic restart_n = 1'b0;

  mine_field_if #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(SW)) bus ();

  mine_field_dp #(.ROWS(ROWS), .COLS(COLS), .NUM_MINES(NM), .SCORE_W(SW)) dut (
    .clka      (clka),
    .restart_n (restart_n),
    .bus       (bus)
  );

  always #5 clka = ~clka;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] e_mines, e_cleared;
  logic [3:0]   e_near;
  logic         e_err, e_go, e_win, e_ready;
  int           e_score;
  bit           track = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Field the datapath must produce for a seed, plus the number of placement cycles.
  function automatic void model_place(input logic [15:0] s, output logic [N-1:0] m, output int cyc);
    logic [15:0] l;
    int placed, cand;
    l = (s == 16'h0000) ? 16'hACE1 : s;
    m = '0; placed = 0; cyc = 0;
    while (placed < int'(NM)) begin
      cand = int'(l) % int'(N);
      if (!m[cand]) begin m[cand] = 1'b1; placed++; end
      l = lfsr_step(l);
      cyc++;
    end
  endfunction

  function automatic int nearby(input logic [N-1:0] m, input int r, input int c);
    int cnt, rj, cj;
    cnt = 0;
    for (int j = 0; j < int'(N); j++) begin
      rj = j / int'(COLS);
      cj = j % int'(COLS);
      if (!(rj == r && cj == c) && (rj - r) <= 1 && (r - rj) <= 1 &&
          (cj - c) <= 1 && (c - cj) <= 1 && m[j]) cnt++;
    end
    return cnt;
  endfunction

  task automatic model_pick(input int r, input int c);
    int safe_clr, idx;
    if (r >= int'(ROWS) || c >= int'(COLS)) begin
      e_err = 1'b1;
    end else begin
      idx          = r * int'(COLS) + c;
      e_err        = 1'b0;
      e_near       = 4'(nearby(e_mines, r, c));
      e_cleared[idx] = 1'b1;
      safe_clr = 0;
      for (int j = 0; j < int'(N); j++) if (e_cleared[j] && !e_mines[j]) safe_clr++;
      if (e_mines[idx]) begin
        e_go = 1'b1; e_win = 1'b0;
      end else if (safe_clr == int'(N - NM)) begin
        e_go = 1'b1; e_win = 1'b1; e_score++;
      end
    end
    e_ready = !e_go;
  endtask

  always @(negedge clka) begin
    if (track) begin
      chk("mines",      64'(bus.mines),        64'(e_mines));
      chk("cleared",    64'(bus.cleared),      64'(e_cleared));
      chk("n_nearby",   64'(bus.n_nearby),     64'(e_near));
      chk("pick_err",   64'(bus.pick_err),     64'(e_err));
      chk("gameover",   64'(bus.gameover),     64'(e_go));
      chk("win",        64'(bus.win),          64'(e_win));
      chk("score",      64'(bus.global_score), 64'(e_score));
      chk("pick_ready", 64'(bus.pick_ready),   64'(e_ready));
    end
  end

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  task automatic do_start(input logic [15:0] s);
    logic [N-1:0] m;
    int cyc, cnt;
    bus.start = 1'b1;
    bus.seed  = s;
    track     = 1'b0;
    step();
    bus.start = 1'b0;
    model_place(s, m, cyc);
    chk("ready_in_place", 64'(bus.pick_ready), 64'(0));
    chk("score_on_start", 64'(bus.global_score), 64'(e_score));
    cnt = 0;
    while (!bus.place_done && cnt < 400) begin
      step();
      cnt++;
    end
    chk("place_latency", 64'(cnt), 64'(cyc));
    chk("place_mines", 64'(bus.mines), 64'(m));
    chk("mine_count", 64'($countones(bus.mines)), 64'(NM));
    e_mines = m; e_cleared = '0; e_near = '0;
    e_err = 1'b0; e_go = 1'b0; e_win = 1'b0; e_ready = 1'b1;
    track = 1'b1;
    step();
    chk("place_done_once", 64'(bus.place_done), 64'(0));
  endtask

  task automatic do_pick(input int r, input int c);
    bus.pick_valid = 1'b1;
    bus.pick_row   = 3'(r);
    bus.pick_col   = 3'(c);
    step();
    bus.pick_valid = 1'b0;
    e_ready = 1'b0;
    chk("rv_in_eval", 64'(bus.result_valid), 64'(0));
    step();
    model_pick(r, c);
    chk("result_valid", 64'(bus.result_valid), 64'(1));
    step();
    chk("rv_pulse", 64'(bus.result_valid), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] pin_map;
    int first_safe, first_mine, r, c, picks;

    bus.start = 1'b0; bus.seed = 16'h0; bus.pick_valid = 1'b0;
    bus.pick_row = '0; bus.pick_col = '0;
    e_score = 0;

    // Model pins against hand-computed values.
    chk("pin_lfsr_step", 64'(lfsr_step(16'hACE1)), 64'h59C3);
    chk("pin_cand_mod", 64'(int'(16'hACE1) % int'(N)), 64'(7));
    pin_map = '0; pin_map[1] = 1'b1; pin_map[5] = 1'b1; pin_map[6] = 1'b1;
    chk("pin_near_corner", 64'(nearby(pin_map, 0, 0)), 64'(3));
    chk("pin_near_far", 64'(nearby(pin_map, 4, 4)), 64'(0));
    pin_map = '1;
    chk("pin_near_full_mid", 64'(nearby(pin_map, 2, 2)), 64'(8));
    chk("pin_near_full_edge", 64'(nearby(pin_map, 4, 2)), 64'(5));

    #22;
    chk("rst_mines", 64'(bus.mines), 64'(0));
    chk("rst_ready", 64'(bus.pick_ready), 64'(0));
    chk("rst_score", 64'(bus.global_score), 64'(0));
    chk("rst_over",  64'({bus.gameover, bus.win, bus.pick_err, bus.result_valid, bus.place_done}), 64'(0));
    restart_n = 1'b1;
    step();
    bus.pick_valid = 1'b1;
    step(); step();
    chk("idle_pick_ignored", 64'({bus.result_valid, bus.pick_ready}), 64'(0));
    bus.pick_valid = 1'b0;

    // Game 1: out-of-range picks, a re-pick, then clear every safe cell to win.
    do_start(16'h1234);
    do_pick(5, 0);
    chk("oor_row_err", 64'(bus.pick_err), 64'(1));
    do_pick(0, 5);
    do_pick(7, 7);
    first_safe = -1;
    for (int j = 0; j < int'(N); j++) if (!e_mines[j] && first_safe < 0) first_safe = j;
    do_pick(first_safe / int'(COLS), first_safe % int'(COLS));
    do_pick(first_safe / int'(COLS), first_safe % int'(COLS));
    for (int j = 0; j < int'(N); j++) begin
      if (!e_mines[j] && j != first_safe) do_pick(j / int'(COLS), j % int'(COLS));
    end
    chk("win_flag", 64'({bus.win, bus.gameover}), 64'(2'b11));
    chk("win_score", 64'(bus.global_score), 64'(1));

    // Game 2: score survives start; hit a mine, then hold pick_valid while over.
    do_start(16'($urandom));
    first_mine = -1;
    for (int j = 0; j < int'(N); j++) if (e_mines[j] && first_mine < 0) first_mine = j;
    do_pick(first_mine / int'(COLS), first_mine % int'(COLS));
    chk("mine_hit", 64'({bus.gameover, bus.win, bus.pick_ready}), 64'(3'b100));
    bus.pick_valid = 1'b1;
    bus.pick_row   = 3'(0);
    bus.pick_col   = 3'(0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("over_pick_ignored", 64'(bus.result_valid), 64'(0));
    end
    bus.pick_valid = 1'b0;

    // Random games, including the zero seed.
    for (int g = 0; g < 8; g++) begin
      do_start((g == 0) ? 16'h0000 : 16'($urandom));
      picks = 0;
      while (!e_go && picks < 60) begin
        r = int'($urandom_range(0, 5));
        c = int'($urandom_range(0, 5));
        do_pick(r, c);
        picks++;
      end
    end

    // Asynchronous reset in the middle of placement.
    bus.start = 1'b1;
    bus.seed  = 16'h1234;
    track     = 1'b0;
    step();
    bus.start = 1'b0;
    step();
    #1 restart_n = 1'b0;
    #1;
    chk("arst_mines",   64'(bus.mines), 64'(0));
    chk("arst_cleared", 64'(bus.cleared), 64'(0));
    chk("arst_score",   64'(bus.global_score), 64'(0));
    chk("arst_flags",   64'({bus.gameover, bus.win, bus.pick_err, bus.result_valid,
                             bus.place_done, bus.pick_ready, bus.n_nearby}), 64'(0));
    restart_n = 1'b1;
    e_score   = 0;
    step(); step();
    chk("arst_idle", 64'({bus.pick_ready, bus.place_done}), 64'(0));
    do_start(16'h1234);
    do_pick(4, 4);

    track = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
